univ_gate_sweep_checker: RTL

//  Synthesisable self-checking exhaustive stimulus engine for universal-gate DUTs (NAND/NOR).
//  - Drives every input combination of an N-input gate.
//  - Waits a programmable settle time per vector.
//  - Compares the DUT output against a golden model and counts mismatches.
//  - Reports pass/fail and the first failing vector.

---
 rtl/univ_gate_sweep_checker_pkg.sv | 15 +
 rtl/univ_gate_sweep_checker_ref.sv | 18 +
 rtl/univ_gate_sweep_checker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/univ_gate_sweep_checker_pkg.sv
// Shared definitions for the universal-gate sweep checker: golden-function
// selectors and the sweep FSM state encoding.
package univ_gate_sweep_checker_pkg;

  localparam int MODE_NAND = 0;
  localparam int MODE_NOR  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/univ_gate_sweep_checker_ref.sv
// Combinational golden model of the gate under test: NAND or NOR of all
// N_IN inputs, selected at elaboration time by MODE.
module univ_gate_ref
  import univ_gate_sweep_checker_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int MODE = MODE_NAND
) (
  input  logic [N_IN-1:0] vec,
  output logic            y
);

  always_comb begin
    if (MODE == MODE_NOR) y = ~|vec;
    else                  y = ~&vec;
  end

endmodule

// File: rtl/univ_gate_sweep_checker.sv
// Exhaustive start/done stimulus engine for an N-input NAND/NOR gate: walks
// every input vector, samples the DUT after SETTLE cycles, counts mismatches.
module univ_gate_sweep_checker
  import univ_gate_sweep_checker_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int MODE   = MODE_NAND,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_out,
  output logic [N_IN-1:0]  vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_vec
);

  localparam logic [3:0]       SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [N_IN-1:0]  VEC_LAST    = '1;
  // With no settle time each vector goes straight to its sample cycle.
  localparam state_e           VEC_ENTRY   = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             first_err_valid_q, first_err_valid_d;
  logic [N_IN-1:0]  first_err_vec_q, first_err_vec_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             golden_y;

  univ_gate_ref #(
    .N_IN (N_IN),
    .MODE (MODE)
  ) u_ref (
    .vec (vec_q),
    .y   (golden_y)
  );

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d           = state_q;
    vec_d             = vec_q;
    settle_cnt_d      = settle_cnt_q;
    err_cnt_d         = err_cnt_q;
    first_err_valid_d = first_err_valid_q;
    first_err_vec_d   = first_err_vec_q;
    pass_d            = pass_q;
    busy_d            = busy_q;
    done_d            = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          vec_d             = '0;
          err_cnt_d         = '0;
          pass_d            = 1'b0;
          first_err_valid_d = 1'b0;
          first_err_vec_d   = '0;
          busy_d            = 1'b1;
          settle_cnt_d      = '0;
          state_d           = VEC_ENTRY;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
        else                             settle_cnt_d = settle_cnt_q + 4'd1;
      end
      ST_SAMPLE: begin
        if (dut_out != golden_y) begin
          if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
          if (!first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_vec_d   = vec_q;
          end
        end
        if (vec_q != VEC_LAST) begin
          vec_d        = vec_q + N_IN'(1);
          settle_cnt_d = '0;
          state_d      = VEC_ENTRY;
        end else begin
          // err_cnt_d already includes this final sample's verdict.
          pass_d  = (err_cnt_d == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      vec_q             <= '0;
      settle_cnt_q      <= '0;
      err_cnt_q         <= '0;
      first_err_valid_q <= 1'b0;
      first_err_vec_q   <= '0;
      pass_q            <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      vec_q             <= vec_d;
      settle_cnt_q      <= settle_cnt_d;
      err_cnt_q         <= err_cnt_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_vec_q   <= first_err_vec_d;
      pass_q            <= pass_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
    end
  end

  assign vec             = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_vec   = first_err_vec_q;

endmodule
